// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit and the decode stage
// that consumes its field slices.
package ifu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
    } ifu_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam logic [31:0] INST_ILLEGAL     = 32'h0000_0000;

    localparam int OPCODE_W  = 7;
    localparam int FUNCT3_W  = 3;
    localparam int FUNCT7_W  = 7;
    localparam int FUNCT12_W = 12;

endpackage

// File: rtl/ifu.sv
// Instruction fetch unit: owns the PC, issues one word read per instruction and
// holds the fetched word until decode accepts it; redirects may arrive at any time.
module ifu
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 imem_req_valid,
    input  logic                 imem_req_ready,
    output logic [31:0]          imem_req_addr,
    input  logic                 imem_rsp_valid,
    input  logic [31:0]          imem_rsp_data,
    input  logic                 imem_rsp_err,
    input  logic                 redirect_valid,
    input  logic [31:0]          redirect_pc,
    output logic                 inst_valid,
    input  logic                 inst_ready,
    output logic [31:0]          inst,
    output logic [31:0]          pcF,
    output logic [31:0]          snpcF,
    output logic [OPCODE_W-1:0]  opcodeF,
    output logic [FUNCT3_W-1:0]  funct3F,
    output logic [FUNCT7_W-1:0]  funct7F,
    output logic [FUNCT12_W-1:0] funct12F,
    output logic                 fetch_err
);

    ifu_state_t  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic        discard_q, discard_d;
    logic [31:0] inst_q, inst_d;
    logic        err_q, err_d;
    logic [31:0] target;

    assign target = redirect_pc & ~32'h3;

    always_comb begin
        // NOTE: every next-value gets its hold default first so no path through
        // the case statement can leave a variable unassigned and infer a latch.
        state_d   = state_q;
        pc_d      = pc_q;
        pend_pc_d = pend_pc_q;
        discard_d = discard_q;
        inst_d    = inst_q;
        err_d     = err_q;

        unique case (state_q)
            IDLE: begin
                state_d = REQ;
                if (redirect_valid) pc_d = target;
            end
            REQ: begin
                // The request already on the bus must complete; remember where to go next.
                if (redirect_valid) begin
                    pend_pc_d = target;
                    discard_d = 1'b1;
                end
                if (imem_req_ready) state_d = WAIT;
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    if (discard_q || redirect_valid) begin
                        state_d   = REQ;
                        pc_d      = redirect_valid ? target : pend_pc_q;
                        discard_d = 1'b0;
                    end else begin
                        state_d = HOLD;
                        inst_d  = imem_rsp_err ? INST_ILLEGAL : imem_rsp_data;
                        err_d   = imem_rsp_err;
                    end
                end else if (redirect_valid) begin
                    pend_pc_d = target;
                    discard_d = 1'b1;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    state_d = REQ;
                    pc_d    = target;
                end else if (inst_ready) begin
                    state_d = REQ;
                    pc_d    = pc_q + 32'd4;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            pend_pc_q <= RESET_PC;
            discard_q <= 1'b0;
            inst_q    <= INST_ILLEGAL;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_pc_q <= pend_pc_d;
            discard_q <= discard_d;
            inst_q    <= inst_d;
            err_q     <= err_d;
        end
    end

    assign imem_req_valid = (state_q == REQ);
    assign imem_req_addr  = pc_q;
    assign inst_valid     = (state_q == HOLD);
    assign inst           = inst_q;
    assign fetch_err      = err_q;
    assign pcF            = pc_q;
    assign snpcF          = pc_q + 32'd4;
    assign opcodeF        = inst_q[6:0];
    assign funct3F        = inst_q[14:12];
    assign funct7F        = inst_q[31:25];
    assign funct12F       = inst_q[31:20];

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: a memory responder checks request addresses and a
// decode-side monitor checks presented instructions against scoreboard queues.
module tb_ifu;
    import ifu_pkg::*;

    localparam logic [31:0] ERR_ADDR = 32'h8000_0300;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid, imem_rsp_err;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid, inst_ready, fetch_err;
    logic [31:0] inst, pcF, snpcF;
    logic [6:0]  opcodeF, funct7F;
    logic [2:0]  funct3F;
    logic [11:0] funct12F;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] addr_q[$];
    int          hs_cyc[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          hs_count = 0;
    int          rsp_delay = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ifu #(.RESET_PC(32'h8000_0000)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
        .pcF(pcF), .snpcF(snpcF), .opcodeF(opcodeF), .funct3F(funct3F),
        .funct7F(funct7F), .funct12F(funct12F), .fetch_err(fetch_err)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == ERR_ADDR) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_0F13);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Expect a request to address a; keep=1 also expects it to reach decode.
    task automatic push_fetch(input logic [31:0] a, input bit keep);
        exp_t e;
        addr_q.push_back(a);
        if (keep) begin
            e.pc   = a;
            e.err  = (a == ERR_ADDR);
            e.word = e.err ? 32'h0000_0000 : mem_word(a);
            exp_q.push_back(e);
        end
    endtask

    // Memory side: checks each accepted address, then answers after rsp_delay extra cycles.
    initial begin
        logic [31:0] a;
        logic [31:0] prev_addr;
        bit          prev_stall;
        prev_stall = 1'b0;
        prev_addr = '0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = '0;
        imem_rsp_err = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_stall)
                check("req_hold", {31'b0, imem_req_valid, imem_req_addr}, {31'b0, 1'b1, prev_addr});
            prev_stall = (imem_req_valid === 1'b1) && (imem_req_ready === 1'b0);
            prev_addr  = imem_req_addr;
            if (imem_req_valid === 1'b1 && imem_req_ready === 1'b1) begin
                a = imem_req_addr;
                if (addr_q.size() == 0) fail("unexpected_request");
                else check("req_addr", {32'b0, a}, {32'b0, addr_q.pop_front()});
                repeat (rsp_delay) @(posedge clk);
                @(posedge clk);
                #1;
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(a);
                imem_rsp_err   = (a == ERR_ADDR);
                @(posedge clk);
                #1;
                imem_rsp_valid = 1'b0;
                imem_rsp_err   = 1'b0;
                prev_stall     = 1'b0;
            end
        end
    end

    // Decode side: compares every presented instruction, pops on handshake or redirect.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (inst_valid === 1'b1) begin
                check("req_in_hold", {63'b0, imem_req_valid}, 64'd0);
                if (exp_q.size() == 0) begin
                    fail("unexpected_inst");
                end else begin
                    e = exp_q[0];
                    check("pcF", {32'b0, pcF}, {32'b0, e.pc});
                    check("snpcF", {32'b0, snpcF}, {32'b0, e.pc + 32'd4});
                    check("inst", {32'b0, inst}, {32'b0, e.word});
                    check("fetch_err", {63'b0, fetch_err}, {63'b0, e.err});
                    check("fields", {35'b0, opcodeF, funct3F, funct7F, funct12F},
                          {35'b0, e.word[6:0], e.word[14:12], e.word[31:25], e.word[31:20]});
                    if (inst_ready === 1'b1 || redirect_valid === 1'b1) begin
                        void'(exp_q.pop_front());
                        hs_cyc.push_back(cyc);
                        hs_count++;
                    end
                end
            end
        end
    end

    task automatic wait_hold();
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (inst_valid === 1'b1) return;
        end
        fail("wait_hold_timeout");
    endtask

    task automatic wait_accept();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (imem_req_valid === 1'b1 && imem_req_ready === 1'b1) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        fail("wait_accept_timeout");
    endtask

    task automatic consume();
        wait_hold();
        inst_ready = 1'b1;
        @(posedge clk);
        #1;
        inst_ready = 1'b0;
    endtask

    task automatic redirect_now(input logic [31:0] a);
        redirect_valid = 1'b1;
        redirect_pc    = a;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        rst = 1'b1;
        inst_ready = 1'b1;
        imem_req_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_valid", {63'b0, imem_req_valid}, 64'd0);
        check("rst_inst_valid", {63'b0, inst_valid}, 64'd0);
        check("rst_inst", {32'b0, inst}, 64'd0);
        check("rst_fetch_err", {63'b0, fetch_err}, 64'd0);
        check("rst_pcF", {32'b0, pcF}, 64'h8000_0000);
        check("rst_snpcF", {32'b0, snpcF}, 64'h8000_0004);

        // Streaming with zero-wait memory and decode always ready.
        push_fetch(32'h8000_0000, 1);
        push_fetch(32'h8000_0004, 1);
        push_fetch(32'h8000_0008, 1);
        push_fetch(32'h8000_000C, 1);
        rst = 1'b0;
        check("idle_cycle_req_valid", {63'b0, imem_req_valid}, 64'd0);
        @(posedge clk);
        #1;
        check("first_req_valid", {63'b0, imem_req_valid}, 64'd1);
        for (int i = 0; i < 40; i++) begin
            if (hs_count >= 3) break;
            @(posedge clk);
            #1;
        end
        inst_ready = 1'b0;
        if (hs_cyc.size() < 3) begin
            fail("stream_handshakes");
        end else begin
            check("throughput_0_1", 64'(hs_cyc[1] - hs_cyc[0]), 64'd3);
            check("throughput_1_2", 64'(hs_cyc[2] - hs_cyc[1]), 64'd3);
        end

        // Decode stall of 5 cycles in HOLD, then a 4-cycle memory stall on the next request.
        wait_hold();
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        push_fetch(32'h8000_0010, 1);
        imem_req_ready = 1'b0;
        inst_ready = 1'b1;
        @(posedge clk);
        #1;
        inst_ready = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        imem_req_ready = 1'b1;
        consume();

        // Redirect while waiting on a slow response: in-flight word is dropped.
        rsp_delay = 2;
        push_fetch(32'h8000_0014, 0);
        push_fetch(32'h8000_0100, 1);
        wait_accept();
        redirect_now(32'h8000_0100);
        consume();

        // Two redirects during one WAIT: only the last target is fetched.
        push_fetch(32'h8000_0104, 0);
        push_fetch(32'h8000_0180, 1);
        wait_accept();
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_0140;
        @(posedge clk);
        #1;
        redirect_pc = 32'h8000_0180;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        consume();

        // Redirect together with inst_ready in HOLD beats pc+4.
        rsp_delay = 0;
        push_fetch(32'h8000_0184, 1);
        push_fetch(32'h8000_0200, 1);
        wait_hold();
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_0200;
        inst_ready = 1'b1;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        inst_ready = 1'b0;

        // Unaligned redirect drops the held word and lands on the faulting address.
        push_fetch(32'h8000_0300, 1);
        wait_hold();
        redirect_now(32'h8000_0303);
        consume();

        // PC wrap at 2^32.
        push_fetch(32'h8000_0304, 1);
        push_fetch(32'hFFFF_FFFC, 1);
        push_fetch(32'h0000_0000, 1);
        push_fetch(32'h0000_0004, 1);
        wait_hold();
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        inst_ready = 1'b1;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        inst_ready = 1'b0;
        consume();
        consume();
        wait_hold();
        imem_req_ready = 1'b0;
        inst_ready = 1'b1;
        @(posedge clk);
        #1;
        inst_ready = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        check("addr_queue_drained", 64'(addr_q.size()), 64'd0);
        check("inst_queue_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
